// File: rtl/irq_sequencer_pkg.sv
// irq_sequencer shared definitions: CP0 map, field positions, FSM states.
// Shared by the sequencer top, its interface and the bench.
package irq_sequencer_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE_BIT = 0;
  localparam int ST_IM_LSB = 8;
  localparam int CA_IP_LSB = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_ENTER  = 3'd2,
    S_ISR    = 3'd3,
    S_RETURN = 3'd4
  } irq_state_e;

  function automatic logic [31:0] vec_addr(
    input logic [31:0] base,
    input logic [2:0]  idx
  );
    return base + {27'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// irq_sequencer bus: interrupt lines, ID-stage status, CP0 access, redirect.
// master = pipeline/controller side, slave = sequencer.
interface irq_sequencer_if #(
  parameter int IRQ_NUM = 4
);
  logic [IRQ_NUM-1:0] irq_in;
  logic               id_valid;
  logic               stall_in;
  logic               branch_id;
  logic               eret_id;
  logic [31:0]        ret_pc;
  logic               cp_wen;
  logic [4:0]         cp_waddr;
  logic [31:0]        cp_wdata;
  logic [4:0]         cp_raddr;
  logic [31:0]        cp_rdata;
  logic               jump_en;
  logic [31:0]        jump_addr;
  logic               ir_en;
  logic [IRQ_NUM-1:0] irq_ack;
  logic [31:0]        epc;

  modport master (
    output irq_in, id_valid, stall_in,
    output branch_id, eret_id, ret_pc,
    output cp_wen, cp_waddr, cp_wdata,
    output cp_raddr,
    input  cp_rdata, jump_en, jump_addr,
    input  ir_en, irq_ack, epc
  );

  modport slave (
    input  irq_in, id_valid, stall_in,
    input  branch_id, eret_id, ret_pc,
    input  cp_wen, cp_waddr, cp_wdata,
    input  cp_raddr,
    output cp_rdata, jump_en, jump_addr,
    output ir_en, irq_ack, epc
  );
endinterface

// File: rtl/irq_sequencer_sync.sv
// irq_sync: parameterized-width 2-flop synchronizer.
// Used by irq_sequencer only when IRQ_SYNC_EN is defined.
module irq_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt entry/ERET sequencer owning CP0 Status/Cause/EPC.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on irq_in.
module irq_sequencer
  import irq_sequencer_pkg::*;
#(
  parameter int          IRQ_NUM     = 4,
  parameter logic [31:0] VECTOR_BASE = 32'h0000_0008
) (
  input logic              clk,
  input logic              rst,
  irq_sequencer_if.slave   bus
);

  logic [IRQ_NUM-1:0] irq_s;
  logic [IRQ_NUM-1:0] im;
  logic [IRQ_NUM-1:0] pending;
  logic [IRQ_NUM-1:0] win_hot;
  logic [IRQ_NUM-1:0] ack_q;
  logic [2:0]         win_idx;
  logic               ie;
  logic [31:0]        epc_q;
  logic [31:0]        epc_fwd;
  logic [31:0]        jaddr_q;
  logic               jen_q;
  logic               safe;
  logic               eret_ok;
  logic               st_wr;
  logic               epc_wr;
  logic               enter_go;
  logic               ret_go;
  logic               ret_done;
  irq_state_e         state;
  irq_state_e         state_nxt;

`ifdef IRQ_SYNC_EN
  irq_sync #(
    .W (IRQ_NUM)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.irq_in),
    .q   (irq_s)
  );
`else
  assign irq_s = bus.irq_in;
`endif

  assign pending = irq_s & im & {IRQ_NUM{ie}};

  // Scan from the top so the lowest pending line is the last one kept.
  always_comb begin
    win_idx = '0;
    win_hot = '0;
    for (int i = IRQ_NUM - 1; i >= 0; i--) begin
      if (pending[i]) begin
        win_idx    = 3'(i);
        win_hot    = '0;
        win_hot[i] = 1'b1;
      end
    end
  end

  assign safe = bus.id_valid & ~bus.stall_in
              & ~bus.branch_id & ~bus.eret_id;

  assign eret_ok = bus.eret_id & bus.id_valid
                 & ~bus.stall_in;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (|pending) state_nxt = S_ARM;
      end
      S_ARM: begin
        if (~|pending)  state_nxt = S_IDLE;
        else if (safe)  state_nxt = S_ENTER;
      end
      S_ENTER:  state_nxt = S_ISR;
      S_ISR: begin
        if (eret_ok) state_nxt = S_RETURN;
      end
      S_RETURN: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  assign enter_go = (state == S_ARM)
                  && (state_nxt == S_ENTER);
  assign ret_go   = (state == S_ISR)
                  && (state_nxt == S_RETURN);
  assign ret_done = (state == S_RETURN);

  assign st_wr  = bus.cp_wen
                && (bus.cp_waddr == CP0_STATUS);
  assign epc_wr = bus.cp_wen
                && (bus.cp_waddr == CP0_EPC);

  // An EPC write on the ERET edge is what the return must use.
  assign epc_fwd = epc_wr ? bus.cp_wdata : epc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jen_q   <= 1'b0;
      ack_q   <= '0;
      jaddr_q <= '0;
    end else begin
      jen_q <= enter_go | ret_go;
      ack_q <= enter_go ? win_hot : '0;
      if (enter_go)
        jaddr_q <= vec_addr(VECTOR_BASE, win_idx);
      else if (ret_go)
        jaddr_q <= epc_fwd;
    end
  end

  // Hardware IE/EPC updates take precedence over MTC0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ie    <= 1'b1;
      im    <= '1;
      epc_q <= '0;
    end else begin
      if (enter_go)      ie <= 1'b0;
      else if (ret_done) ie <= 1'b1;
      else if (st_wr)    ie <= bus.cp_wdata[ST_IE_BIT];
      if (st_wr)
        im <= bus.cp_wdata[ST_IM_LSB +: IRQ_NUM];
      if (enter_go)      epc_q <= bus.ret_pc;
      else if (epc_wr)   epc_q <= bus.cp_wdata;
    end
  end

  always_comb begin
    bus.cp_rdata = '0;
    unique case (1'b1)
      (bus.cp_raddr == CP0_STATUS): begin
        bus.cp_rdata[ST_IE_BIT]            = ie;
        bus.cp_rdata[ST_IM_LSB +: IRQ_NUM] = im;
      end
      (bus.cp_raddr == CP0_CAUSE): begin
        bus.cp_rdata[CA_IP_LSB +: IRQ_NUM] = irq_s;
      end
      (bus.cp_raddr == CP0_EPC): begin
        bus.cp_rdata = epc_q;
      end
      default: bus.cp_rdata = '0;
    endcase
  end

  assign bus.jump_en   = jen_q;
  assign bus.jump_addr = jaddr_q;
  assign bus.irq_ack   = ack_q;
  assign bus.ir_en     = ie;
  assign bus.epc       = epc_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// Scoreboard bench for irq_sequencer: expected redirects are queued
// as stimulus is driven and matched when jump_en appears.
module tb_irq_sequencer;
  import irq_sequencer_pkg::*;

  localparam int N = 4;
`ifdef IRQ_SYNC_EN
  localparam int BASE = 4;
`else
  localparam int BASE = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  irq_sequencer_if #(.IRQ_NUM(N)) bus();

  irq_sequencer #(
    .IRQ_NUM     (N),
    .VECTOR_BASE (32'h0000_0008)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [N-1:0] ack;
    logic [31:0]  epc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_run = 0;
  int   n_fail = 0;
  logic prev_jen = 1'b0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.jump_en) begin
      if (prev_jen)
        check("jump_back2back", 32'd1, 32'd0);
      check("jump_ir_en", 32'(bus.ir_en), 32'd0);
      if (sb.size() == 0) begin
        check("spurious_jump", bus.jump_addr,
              32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("jump_addr", bus.jump_addr, mon_e.addr);
        check("irq_ack", 32'(bus.irq_ack),
              32'(mon_e.ack));
        check("jump_epc", bus.epc, mon_e.epc);
      end
    end
    prev_jen = bus.jump_en;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n, input string tag);
    int j = 0;
    repeat (n) begin
      cyc();
      if (bus.jump_en) j++;
    end
    check(tag, 32'(j), 32'd0);
  endtask

  task automatic cp_write(
    input logic [4:0]  a,
    input logic [31:0] d
  );
    bus.cp_wen   = 1'b1;
    bus.cp_waddr = a;
    bus.cp_wdata = d;
    cyc();
    bus.cp_wen   = 1'b0;
  endtask

  task automatic cp_read(
    input logic [4:0]  a,
    input logic [31:0] exp,
    input string       tag
  );
    bus.cp_raddr = a;
    #1;
    check(tag, bus.cp_rdata, exp);
  endtask

  // Edge k of the loop sees stall while k<=stall_last, branch at br_edge.
  task automatic enter(
    input logic [N-1:0] irq,
    input logic [31:0]  rpc,
    input int           stall_last,
    input int           br_edge,
    input int           exp_lat,
    input bit           push,
    input string        tag
  );
    int   idx = 0;
    int   k = 0;
    exp_t e;
    for (int i = N - 1; i >= 0; i--)
      if (irq[i]) idx = i;
    e.addr = 32'(32'h8 + 4 * idx);
    e.ack = '0;
    e.ack[idx] = 1'b1;
    e.epc = rpc;
    if (push) sb.push_back(e);
    bus.irq_in   = irq;
    bus.ret_pc   = rpc;
    bus.id_valid = 1'b1;
    while (k < 40 && !bus.jump_en) begin
      bus.stall_in  = (k <= stall_last);
      bus.branch_id = (k == br_edge);
      cyc();
      k++;
    end
    bus.stall_in  = 1'b0;
    bus.branch_id = 1'b0;
    check({tag, "_latency"}, 32'(k), 32'(exp_lat));
  endtask

  task automatic do_eret(
    input logic [31:0] target,
    input string       tag
  );
    exp_t e;
    e.addr = target;
    e.ack = '0;
    e.epc = target;
    sb.push_back(e);
    bus.id_valid = 1'b1;
    bus.eret_id  = 1'b1;
    cyc();
    bus.eret_id  = 1'b0;
    check({tag, "_jump"}, 32'(bus.jump_en), 32'd1);
    cyc();
    check({tag, "_ir_en"}, 32'(bus.ir_en), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.irq_in    = '0;
    bus.id_valid  = 1'b1;
    bus.stall_in  = 1'b0;
    bus.branch_id = 1'b0;
    bus.eret_id   = 1'b0;
    bus.ret_pc    = '0;
    bus.cp_wen    = 1'b0;
    bus.cp_waddr  = '0;
    bus.cp_wdata  = '0;
    bus.cp_raddr  = '0;

    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    check("rst_jump_en", 32'(bus.jump_en), 32'd0);
    check("rst_jump_addr", bus.jump_addr, 32'd0);
    check("rst_irq_ack", 32'(bus.irq_ack), 32'd0);
    check("rst_epc", bus.epc, 32'd0);
    check("rst_ir_en", 32'(bus.ir_en), 32'd1);
    cp_read(CP0_STATUS, 32'h0000_0F01, "rst_status");
    cp_read(CP0_EPC, 32'h0, "rst_epc_rd");
    cp_read(5'd3, 32'h0, "unmapped_rd");

    enter(4'b0100, 32'h40, -1, -1, BASE, 1'b1, "t1");
    check("t1_ir_en", 32'(bus.ir_en), 32'd0);
    check("t1_epc", bus.epc, 32'h40);
    cyc();
    check("t1_pulse", 32'(bus.jump_en), 32'd0);
    check("t1_ack_clr", 32'(bus.irq_ack), 32'd0);
    bus.irq_in = '0;
    quiet(5, "t1_isr_quiet");
    do_eret(32'h40, "t1_eret");
    quiet(3, "t1_post");

    enter(4'b0110, 32'h80, -1, -1, BASE, 1'b1, "t2");
    bus.irq_in = 4'b0001;
    quiet(4, "t2_isr_a");
    bus.irq_in = 4'b1111;
    quiet(4, "t2_isr_b");
    bus.irq_in = '0;
    quiet(4, "t2_isr_c");
    cp_write(CP0_EPC, 32'h200);
    cp_read(CP0_EPC, 32'h200, "t4_epc_rd");
    check("t4_epc", bus.epc, 32'h200);
    do_eret(32'h200, "t4_eret");

    bus.eret_id = 1'b1;
    quiet(4, "t4_eret_idle");
    bus.eret_id = 1'b0;

    cp_write(CP0_STATUS, 32'h0000_0E01);
    cp_read(CP0_STATUS, 32'h0000_0E01, "t5_status");
    bus.irq_in = 4'b0001;
    quiet(6, "t5_masked");
    cp_read(CP0_CAUSE, 32'h0000_0100, "t5_cause");
    bus.irq_in = '0;
    quiet(3, "t5_clear");
    cp_write(CP0_STATUS, 32'h0000_0F01);

    bus.stall_in = 1'b1;
    bus.irq_in   = 4'b0001;
    repeat (BASE + 2) cyc();
    bus.irq_in   = '0;
    quiet(4, "t5_drop_stalled");
    bus.stall_in = 1'b0;
    quiet(6, "t5_drop");
    check("t5_no_ack", 32'(bus.irq_ack), 32'd0);

    enter(4'b0001, 32'h300, BASE + 1, BASE + 2,
          BASE + 4, 1'b1, "t3");
    bus.irq_in = '0;
    quiet(4, "t3_isr");
    do_eret(32'h300, "t3_eret");

    quiet(2, "t6_pre");
    enter(4'b1000, 32'h500, -1, -1, BASE, 1'b0, "t6");
    rst = 1'b0;
    #1;
    check("t6_jump_en", 32'(bus.jump_en), 32'd0);
    check("t6_epc", bus.epc, 32'd0);
    check("t6_ir_en", 32'(bus.ir_en), 32'd1);
    check("t6_ack", 32'(bus.irq_ack), 32'd0);
    check("t6_jaddr", bus.jump_addr, 32'd0);
    bus.irq_in = '0;
    cyc();
    rst = 1'b1;
    quiet(5, "t6_post");
    cp_read(CP0_STATUS, 32'h0000_0F01, "t6_status");

    enter(4'b1000, 32'h600, -1, -1, BASE, 1'b1, "t7");
    bus.irq_in = '0;
    quiet(4, "t7_isr");
    do_eret(32'h600, "t7_eret");
    quiet(3, "t7_post");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
